// File: rtl/ngp_mc_core.sv
// ngp_mc_core - multi-cycle core for a 16-bit two-register (A/D) instruction set.
//
// Each instruction is fetched in FETCH, then decoded and executed in EXEC.
// A compute instruction that reads *A visits MEM_RD first. One that writes *A
// visits MEM_WR after the ALU result is known. When the instruction retires,
// every selected destination, pc and the jump decision update on the same edge.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   imem_addr   instruction fetch address (the pc)
//   imem_data   16-bit instruction word
//   imem_valid  imem_data is valid for imem_addr this cycle
//   dmem_req    data-memory request, held until dmem_ack
//   dmem_we     1 = write, 0 = read
//   dmem_addr   data address (A as it was at instruction start)
//   dmem_wdata  write data (ALU result)
//   dmem_rdata  read data, valid in the ack cycle
//   dmem_ack    request completed
//   a_q, d_q    architectural A and D registers
//   halted      core stopped on a self-jump, until reset
module ngp_mc_core #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [15:0]      imem_data,
    input  logic             imem_valid,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] d_q,
    output logic             halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [15:0]      ir;
    logic [WIDTH-1:0] mem_q;    // *A captured on the read ack
    logic             rd_done;  // the read phase of this instruction is complete

    // Decoded instruction fields
    logic       is_comp;
    logic       use_m;
    logic       alu_u;
    logic [1:0] alu_op;
    logic       alu_zx;
    logic       alu_sw;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    logic [2:0] jmp;

    assign is_comp = ir[15];
    assign use_m   = ir[12];
    assign alu_u   = ir[10];
    assign alu_op  = ir[9:8];
    assign alu_zx  = ir[7];
    assign alu_sw  = ir[6];
    assign dest_a  = ir[5];
    assign dest_d  = ir[4];
    assign dest_m  = ir[3];
    assign jmp     = ir[2:0];

    // ALU: the swap is applied before the zero-forcing of X.
    function automatic logic [WIDTH-1:0] alu(
        input logic [WIDTH-1:0] d_in,
        input logic [WIDTH-1:0] y_in,
        input logic             u,
        input logic [1:0]       op,
        input logic             zx,
        input logic             sw
    );
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        x = sw ? y_in : d_in;
        y = sw ? d_in : y_in;
        if (zx) begin
            x = '0;
        end
        if (u) begin
            case (op)
                2'b00:   alu = x + y;
                2'b01:   alu = x + ONE;
                2'b10:   alu = x - y;
                default: alu = x - ONE;
            endcase
        end else begin
            case (op)
                2'b00:   alu = x & y;
                2'b01:   alu = x | y;
                2'b10:   alu = x ^ y;
                default: alu = ~x;
            endcase
        end
    endfunction

    logic [WIDTH-1:0]        y_sel;
    logic [WIDTH-1:0]        alu_res;
    logic signed [WIDTH-1:0] res_s;
    logic                    res_neg;
    logic                    res_zero;
    logic                    res_pos;
    logic                    jump_taken;
    logic                    halt_hit;
    logic [WIDTH-1:0]        pc_inc;
    logic [WIDTH-1:0]        imm_ext;

    assign y_sel    = use_m ? mem_q : a_q;
    assign alu_res  = alu(d_q, y_sel, alu_u, alu_op, alu_zx, alu_sw);
    assign res_s    = alu_res;
    assign res_neg  = (res_s < 0);
    assign res_zero = (alu_res == '0);
    assign res_pos  = !res_neg && !res_zero;

    assign jump_taken = is_comp &&
                        ((jmp[2] && res_neg) || (jmp[1] && res_zero) || (jmp[0] && res_pos));
    // A self-jump that is unconditional is the program's way of stopping.
    assign halt_hit   = jump_taken && (jmp == 3'b111) && (a_q == pc);
    assign pc_inc     = pc + ONE;
    assign imm_ext    = {{(WIDTH-15){1'b0}}, ir[14:0]};

    // A stays at its start-of-instruction value until retire, so both the data
    // address and the jump target come straight from a_q. The ALU inputs are
    // also frozen during MEM_WR, which keeps dmem_wdata stable for the request.
    assign imem_addr  = pc;
    assign dmem_req   = (state == MEM_RD) || (state == MEM_WR);
    assign dmem_we    = (state == MEM_WR);
    assign dmem_addr  = a_q;
    assign dmem_wdata = alu_res;
    assign halted     = (state == HALT);

    logic retire;

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!is_comp) begin
                    retire = 1'b1;
                end else if (use_m && !rd_done) begin
                    state_nxt = MEM_RD;
                end else if (dest_m) begin
                    state_nxt = MEM_WR;
                end else begin
                    retire = 1'b1;
                end
            end
            MEM_RD: begin
                // Return to EXEC so that dmem_req drops for a cycle between
                // the read and any following write.
                if (dmem_ack) begin
                    state_nxt = EXEC;
                end
            end
            MEM_WR: begin
                if (dmem_ack) begin
                    retire = 1'b1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        if (retire) begin
            state_nxt = halt_hit ? HALT : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            a_q     <= '0;
            d_q     <= '0;
            rd_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_valid) begin
                rd_done <= 1'b0;
            end else if (state == MEM_RD && dmem_ack) begin
                rd_done <= 1'b1;
            end
            if (retire) begin
                pc <= jump_taken ? a_q : pc_inc;
                if (!is_comp) begin
                    a_q <= imm_ext;
                end else if (dest_a) begin
                    a_q <= alu_res;
                end
                if (is_comp && dest_d) begin
                    d_q <= alu_res;
                end
            end
        end
    end

    // The instruction and read-data holding registers need no reset. They are
    // always written before they are used.
    always_ff @(posedge clk) begin
        if (state == FETCH && imem_valid) begin
            ir <= imem_data;
        end
        if (state == MEM_RD && dmem_ack) begin
            mem_q <= dmem_rdata;
        end
    end

endmodule

// File: tb/tb_ngp_mc_core.sv
module tb_ngp_mc_core;

    localparam int          WIDTH    = 16;
    localparam logic [15:0] RESET_PC = 16'h0040;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic        halted;

    ngp_mc_core #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .a_q        (a_q),
        .d_q        (d_q),
        .halted     (halted)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic [15:0] prog [256];
    logic        imem_en;
    assign imem_data  = prog[imem_addr[7:0]];
    assign imem_valid = imem_en;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          errors;
    int          checks;
    int          ack_delay;
    int          req_cycles;
    logic [15:0] rd_data;
    logic        spurious;

    // Memory responder and scoreboard. Each request is acknowledged after
    // ack_delay wait cycles. The acknowledged request is then compared with
    // the next expected transaction.
    task automatic responder();
        int   cnt;
        txn_t t;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dmem_ack = 1'b0;
                cnt = 0;
            end else if (dmem_req) begin
                req_cycles++;
                if (cnt == ack_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rd_data;
                    cnt = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL dmem_unexpected: got we=%b addr=%h wdata=%h, required no request",
                                 dmem_we, dmem_addr, dmem_wdata);
                    end else begin
                        t = exp_q.pop_front();
                        if (dmem_we !== t.we || dmem_addr !== t.addr ||
                            (t.we && dmem_wdata !== t.wdata)) begin
                            errors++;
                            $display("FAIL dmem_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                     dmem_we, dmem_addr, dmem_wdata, t.we, t.addr, t.wdata);
                        end
                    end
                end else begin
                    dmem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                dmem_ack   = spurious;
                dmem_rdata = 16'hDEAD;
                cnt = 0;
            end
        end
    endtask

    // Present one instruction at the current pc for a single fetch, then
    // let the instruction run for a total of cyc cycles.
    task automatic issue(input logic [15:0] instr, input int cyc);
        prog[imem_addr[7:0]] = instr;
        imem_en = 1'b1;
        @(posedge clk);
        #1;
        imem_en = 1'b0;
        repeat (cyc - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h required %h", imem_addr, RESET_PC); end
        checks++; if (a_q !== 16'h0000) begin errors++; $display("FAIL reset_a: got %h required 0000", a_q); end
        checks++; if (d_q !== 16'h0000) begin errors++; $display("FAIL reset_d: got %h required 0000", d_q); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", dmem_we); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        imem_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL fetch_hold_pc: got %h required %h", imem_addr, RESET_PC); end
            checks++; if (a_q !== 16'h0000) begin errors++; $display("FAIL fetch_hold_a: got %h required 0000", a_q); end
        end
        issue(16'h0005, 2);
        checks++; if (a_q !== 16'h0005) begin errors++; $display("FAIL load_a: got %h required 0005", a_q); end
        checks++; if (imem_addr !== RESET_PC + 16'd1) begin errors++; $display("FAIL load_pc: got %h required %h", imem_addr, RESET_PC + 16'd1); end
    endtask

    task automatic test_alu_jump();
        issue(16'h0003, 2);          // A = 3
        issue(16'h8490, 2);          // D = A
        checks++; if (d_q !== 16'h0003) begin errors++; $display("FAIL d_eq_a: got %h required 0003", d_q); end
        issue(16'h0005, 2);          // A = 5
        issue(16'h8614, 2);          // D = D - A ; JLT
        checks++; if (d_q !== 16'hFFFE) begin errors++; $display("FAIL sub_d: got %h required FFFE", d_q); end
        checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL jlt_taken: got %h required 0005", imem_addr); end
        spurious = 1'b1;             // stray acks while no request is pending
        issue(16'h8611, 2);          // D = D - A ; JGT
        spurious = 1'b0;
        checks++; if (d_q !== 16'hFFF9) begin errors++; $display("FAIL sub_d2: got %h required FFF9", d_q); end
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL jgt_not_taken: got %h required 0006", imem_addr); end
    endtask

    task automatic test_alu_ops();
        logic [15:0] ops [9];
        logic [15:0] res [9];
        ops = '{16'h8010, 16'h8110, 16'h8310, 16'h8210, 16'h8510,
                16'h8710, 16'h8650, 16'h8410, 16'h8390};
        res = '{16'h000F, 16'h00FF, 16'hFF00, 16'hFFFF, 16'h0000,
                16'hFFFF, 16'h0100, 16'h01FF, 16'hFFFF};
        issue(16'h0F0F, 2);
        issue(16'h8490, 2);          // D = 0x0F0F
        issue(16'h00FF, 2);          // A = 0x00FF
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], 2);
            checks++; if (d_q !== res[i]) begin errors++; $display("FAIL alu_op%0d (%h): got %h required %h", i, ops[i], d_q, res[i]); end
        end
        issue(16'h8512, 2);          // D = D + 1 ; JEQ  (wraps to 0)
        checks++; if (d_q !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h required 0000", d_q); end
        checks++; if (imem_addr !== 16'h00FF) begin errors++; $display("FAIL jeq_taken: got %h required 00FF", imem_addr); end
        issue(16'h8571, 2);          // A,D = A + 1 ; JGT to the old A
        checks++; if (a_q !== 16'h0100) begin errors++; $display("FAIL multi_dest_a: got %h required 0100", a_q); end
        checks++; if (d_q !== 16'h0100) begin errors++; $display("FAIL multi_dest_d: got %h required 0100", d_q); end
        checks++; if (imem_addr !== 16'h00FF) begin errors++; $display("FAIL jump_old_a: got %h required 00FF", imem_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL no_halt: got %b required 0", halted); end
    endtask

    task automatic test_mem_read();
        int start;
        issue(16'h0010, 2);          // A = 0x10
        ack_delay = 3;
        rd_data   = 16'h1234;
        exp_q.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0000});
        start = req_cycles;
        issue(16'h9490, 7);          // D = *A
        checks++; if (d_q !== 16'h1234) begin errors++; $display("FAIL read_d: got %h required 1234", d_q); end
        checks++; if (req_cycles - start !== 4) begin errors++; $display("FAIL read_req_len: got %0d required 4", req_cycles - start); end
        checks++; if (imem_addr !== 16'h0101) begin errors++; $display("FAIL read_pc: got %h required 0101", imem_addr); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL read_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int start;
        issue(16'h0020, 2);          // A = 0x20
        ack_delay = 1;
        rd_data   = 16'h0007;
        exp_q.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
        exp_q.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h0008});
        start = req_cycles;
        issue(16'h9548, 7);          // *A = *A + 1
        checks++; if (req_cycles - start !== 4) begin errors++; $display("FAIL rmw_req_len: got %0d required 4", req_cycles - start); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rmw_pending: got %0d required 0", exp_q.size()); end
        checks++; if (imem_addr !== 16'h0103) begin errors++; $display("FAIL rmw_pc: got %h required 0103", imem_addr); end
        checks++; if (a_q !== 16'h0020) begin errors++; $display("FAIL rmw_a: got %h required 0020", a_q); end
    endtask

    task automatic test_reset_mid_write();
        ack_delay = 10;
        exp_q.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h1234});
        issue(16'h84E8, 2);          // A,*A = D ; now waiting in MEM_WR
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL wr_wait: got req=%b we=%b required 1 1", dmem_req, dmem_we); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b required 0", dmem_req); end
        checks++; if (a_q !== 16'h0000) begin errors++; $display("FAIL abort_a: got %h required 0000", a_q); end
        checks++; if (d_q !== 16'h0000) begin errors++; $display("FAIL abort_d: got %h required 0000", d_q); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL abort_pc: got %h required %h", imem_addr, RESET_PC); end
        exp_q.delete();
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_halt();
        issue(16'h0041, 2);          // A = 0x41 (the next pc)
        issue(16'h8007, 2);          // unconditional jump to self
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b required 1", halted); end
        checks++; if (imem_addr !== 16'h0041) begin errors++; $display("FAIL halt_pc: got %h required 0041", imem_addr); end
        imem_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        imem_en = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b required 1", halted); end
        checks++; if (imem_addr !== 16'h0041) begin errors++; $display("FAIL halt_hold_pc: got %h required 0041", imem_addr); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL halt_req: got %b required 0", dmem_req); end
        rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b required 0", halted); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL halt_reset_pc: got %h required %h", imem_addr, RESET_PC); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        req_cycles = 0;
        ack_delay  = 0;
        rd_data    = 16'h0000;
        spurious   = 1'b0;
        imem_en    = 1'b0;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        fork
            responder();
        join_none
        test_reset();
        test_fetch();
        test_alu_jump();
        test_alu_ops();
        test_mem_read();
        test_back_to_back();
        test_reset_mid_write();
        test_halt();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ngp_mc_core.md
NGP_MC_CORE -- requirements
Module: ngp_mc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data/address width (legal values >= 16).
REQ-002 SHALL have parameter RESET_PC, default 0, meaning program counter value after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_addr, output, WIDTH bits: instruction fetch address, equal to pc.
REQ-006 SHALL have port imem_data, input, 16 bits: instruction word.
REQ-007 SHALL have port imem_valid, input, 1 bit: imem_data is valid for imem_addr this cycle.
REQ-008 SHALL have port dmem_req, output, 1 bit: data-memory request.
REQ-009 SHALL have port dmem_we, output, 1 bit: write (1) or read (0).
REQ-010 SHALL have ports dmem_addr (output, WIDTH bits), dmem_wdata (output, WIDTH bits) and dmem_rdata (input, WIDTH bits).
REQ-011 SHALL have port dmem_ack, input, 1 bit: request completed; read data is valid in the same cycle.
REQ-012 SHALL have ports a_q and d_q, output, WIDTH bits each: the A and D registers; and port halted, output, 1 bit: core stopped.

Function
REQ-013 Encoding SHALL be: bit15=0 loads imm[14:0], zero-extended, into A. bit15=1 is compute: bit12 selects Y (0: A, 1: *A); bits10..6 = u,op1,op0,zx,sw; bits5..3 = dest A, D, *A; bits2..0 = jump lt, eq, gt.
REQ-014 ALU SHALL use X=D and Y per bit12. sw swaps X and Y, then zx forces X=0.
REQ-015 ALU with u=1 SHALL compute op 00 X+Y, 01 X+1, 10 X-Y, 11 X-1; with u=0, op 00 X&Y, 01 X|Y, 10 X^Y, 11 ~X. Results SHALL be modulo 2^WIDTH.
REQ-016 FSM states SHALL be FETCH, EXEC, MEM_RD, MEM_WR and HALT.
REQ-017 In FETCH, if imem_valid=1 the core SHALL latch imem_data into the instruction register and go to EXEC; otherwise it SHALL stay in FETCH.
REQ-018 In EXEC, a compute instruction with bit12=1 SHALL go to MEM_RD before computing.
REQ-019 In EXEC, a compute instruction with dest *A SHALL go to MEM_WR after computing, once any read has completed.
REQ-020 An instruction needing neither read nor write SHALL retire in EXEC, giving a minimum of 2 cycles per instruction.
REQ-021 In MEM_RD/MEM_WR, dmem_req=1 with dmem_addr=A (value at instruction start) and stable dmem_we/dmem_wdata SHALL be held until dmem_ack.
REQ-022 dmem_req SHALL deassert in the cycle after the ack cycle.
REQ-023 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-024 A read-and-write of *A in one instruction SHALL read first, then write the ALU result, issuing two separate requests.
REQ-025 At retire, all selected destinations SHALL update simultaneously.
REQ-026 Jump SHALL be taken if (lt and result<0) or (eq and result==0) or (gt and result>0), with the result signed.
REQ-027 The jump target SHALL be A as it was at instruction start, not as written by this instruction.
REQ-028 At retire, pc SHALL become the target if the jump is taken, else pc+1 (wrapping at 2^WIDTH); the FSM SHALL then go to FETCH.
REQ-029 A taken jump with all three jump bits set and target==pc SHALL enter HALT: halted=1, no further fetches or requests, held until reset.

Reset
REQ-030 While rst=1 (asynchronously): pc=RESET_PC, A=0, D=0, state=FETCH, dmem_req=0, dmem_we=0, halted=0.
REQ-031 A reset mid-transaction SHALL drop dmem_req immediately, with no register or memory update from the aborted instruction.

Verification
REQ-032 Reset, then fetch 0x0005 -> a_q=0x0005, pc=RESET_PC+1 after 2 cycles; imem_valid low 3 cycles -> FETCH held, pc unchanged.
REQ-033 A=5, D=3, instruction D=D-A (u=1, op=10, dest D) -> d_q=0xFFFE; jump lt taken to A=5, gt not taken.
REQ-034 A=0x10, instruction D=*A with ack delayed 3 cycles, rdata=0x1234 -> dmem_req high exactly 4 cycles, dmem_we=0, d_q=0x1234.
REQ-035 Instruction *A=*A+1 at A=0x20, rdata=7 -> read request then write request with wdata=8, two acks, pc+1.
REQ-036 A=pc, unconditional jump -> halted=1, imem_valid ignored; rst -> halted=0, pc=RESET_PC.
REQ-037 rst asserted during MEM_WR wait -> dmem_req=0 the same cycle; A, D unchanged from reset values.
